mem_serial_slave: RTL and testbench



---
 rtl/mem_serial_pkg.sv | 21 ++
 rtl/serial_shift_reg.sv | 30 +++
 rtl/mem_serial_slave.sv | 143 ++++++++++++++
 tb/tb_mem_serial_slave.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_serial_pkg.sv
// Shared types and constants for the bit-serial RAM slave.
package mem_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    ACK,
    LOAD,
    RDATA,
    WAIT_REL
  } slave_state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/serial_shift_reg.sv
// Left-shifting register with parallel load; serial in at LSB, serial out at MSB.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift_en,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift_en) begin
      r_q <= {r_q[WIDTH-2:0], i_sin};
    end
  end

  assign o_q    = r_q;
  assign o_sout = r_q[WIDTH-1];

endmodule

// File: rtl/mem_serial_slave.sv
// Bit-serial bus slave driving the data RAM: mode bit, address, optional write
// data in; single-cycle write pulse or serialised read data out.
module mem_serial_slave
  import mem_serial_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              s_valid,
  input  logic              s_din,
  output logic              s_dout,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  slave_state_t r_state;
  slave_state_t w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_mode;
  logic w_addr_shift;
  logic w_wdata_shift;
  logic w_rd_load;
  logic w_rd_shift;
  logic w_rd_msb;
  logic w_unused_addr_sout;
  logic w_unused_wdata_sout;
  logic [DATA_W-1:0] w_unused_rd_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter restarts on every state change so each field counts from zero.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state == ADDR || r_state == WDATA || r_state == RDATA) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_mode <= MODE_READ;
    end else if (r_state == IDLE && s_valid) begin
      r_mode <= s_din;
    end
  end

  always_comb begin
    w_next   = r_state;
    mem_wren = 1'b0;
    s_ready  = 1'b0;
    s_dout   = 1'b0;
    unique case (r_state)
      IDLE: if (s_valid) w_next = ADDR;
      ADDR: begin
        if (!s_valid) w_next = IDLE;
        else if (r_cnt == ADDR_LAST) w_next = (r_mode == MODE_WRITE) ? WDATA : LOAD;
      end
      WDATA: begin
        if (!s_valid) w_next = IDLE;
        else if (r_cnt == DATA_LAST) w_next = WRITE;
      end
      // Write is committed once here; s_valid no longer aborts.
      WRITE: begin
        mem_wren = 1'b1;
        w_next   = ACK;
      end
      ACK: begin
        s_ready = 1'b1;
        w_next  = WAIT_REL;
      end
      LOAD: w_next = s_valid ? RDATA : IDLE;
      RDATA: begin
        if (!s_valid) begin
          w_next = IDLE;
        end else begin
          s_ready = 1'b1;
          s_dout  = w_rd_msb;
          if (r_cnt == DATA_LAST) w_next = WAIT_REL;
        end
      end
      WAIT_REL: if (!s_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_addr_shift  = (r_state == ADDR) && s_valid;
  assign w_wdata_shift = (r_state == WDATA) && s_valid;
  assign w_rd_load     = (r_state == LOAD);
  assign w_rd_shift    = (r_state == RDATA);

  serial_shift_reg #(.WIDTH(ADDR_W)) u_addr_deser (
    .clk         (clock),
    .rst_n       (rstn),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift_en  (w_addr_shift),
    .i_sin       (s_din),
    .o_q         (mem_address),
    .o_sout      (w_unused_addr_sout)
  );

  serial_shift_reg #(.WIDTH(DATA_W)) u_wdata_deser (
    .clk         (clock),
    .rst_n       (rstn),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift_en  (w_wdata_shift),
    .i_sin       (s_din),
    .o_q         (mem_data_in),
    .o_sout      (w_unused_wdata_sout)
  );

  serial_shift_reg #(.WIDTH(DATA_W)) u_rdata_ser (
    .clk         (clock),
    .rst_n       (rstn),
    .i_load      (w_rd_load),
    .i_load_data (mem_data_out),
    .i_shift_en  (w_rd_shift),
    .i_sin       (1'b0),
    .o_q         (w_unused_rd_q),
    .o_sout      (w_rd_msb)
  );

endmodule

// File: tb/tb_mem_serial_slave.sv
// Self-checking bench for mem_serial_slave with a behavioural 4K x 8 RAM.
module tb_mem_serial_slave;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_din = 1'b0;
  logic        s_dout;
  logic        s_ready;
  logic        mem_wren;
  logic [11:0] mem_address;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;

  logic [7:0]  ram [4096];
  logic [7:0]  exp_mem [4096];
  logic        ram_init_done = 1'b0;

  int total = 0;
  int bad = 0;
  logic [19:0] wq[$];
  bit          rq[$];

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl [10];

  mem_serial_slave #(.ADDR_W(12), .DATA_W(8)) dut (
    .clock        (clock),
    .rstn         (rstn),
    .s_valid      (s_valid),
    .s_din        (s_din),
    .s_dout       (s_dout),
    .s_ready      (s_ready),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_wren     (mem_wren),
    .mem_data_out (mem_data_out)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input int i);
    logic [11:0] x;
    x = 12'(i);
    return x[7:0] ^ {x[11:8], x[11:8]} ^ 8'h96;
  endfunction

  assign mem_data_out = ram[mem_address];

  always @(posedge clock) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else if (mem_wren) begin
      ram[mem_address] <= mem_data_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Write scoreboard: every wren pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (mem_wren) begin
      check("ready_wren_excl", {31'd0, s_ready}, 0);
      if (wq.size() == 0) check("wren_unexpected", {31'd0, mem_wren}, 0);
      else check("wren_txn", {12'd0, mem_address, mem_data_in}, {12'd0, wq.pop_front()});
    end
  end

  task automatic txn(input bit wr, input logic [11:0] a, input logic [7:0] d,
                     input int abort_k, input int rst_k, input int hold);
    logic [20:0] seq;
    logic [7:0]  rv;
    int          last;
    seq  = {wr, a, d};
    last = (wr ? 23 : 22) + hold;
    if (abort_k < 0 && rst_k < 0) begin
      if (wr) begin
        wq.push_back({a, d});
        exp_mem[a] = d;
      end else begin
        rv = exp_mem[a];
        for (int i = 7; i >= 0; i--) rq.push_back(rv[i]);
      end
    end
    for (int k = 0; k <= last; k++) begin
      @(negedge clock);
      if (k == rst_k) begin
        rstn = 1'b0;
        s_valid = 1'b0;
        #1;
        check("rst_mid_outputs", {9'd0, s_dout, s_ready, mem_wren, mem_address, mem_data_in}, 0);
        repeat (2) @(negedge clock);
        rstn = 1'b1;
        return;
      end
      if (k == abort_k) begin
        s_valid = 1'b0;
        @(negedge clock);
        check("abort_quiet", {29'd0, s_ready, s_dout, mem_wren}, 0);
        return;
      end
      if (k > 0) begin
        if (wr) begin
          if (k == 21) begin
            check("wr_wren", {31'd0, mem_wren}, 1);
            check("wr_addr", {20'd0, mem_address}, {20'd0, a});
            check("wr_data", {24'd0, mem_data_in}, {24'd0, d});
            check("wr_ready_lo", {31'd0, s_ready}, 0);
          end else if (k == 22) begin
            check("wr_ack", {30'd0, s_ready, mem_wren}, 2);
          end else begin
            check("wr_quiet", {30'd0, s_ready, mem_wren}, 0);
          end
        end else begin
          if (k >= 14 && k <= 21) begin
            check("rd_strobe", {30'd0, s_ready, mem_wren}, 2);
            if (s_ready) begin
              if (rq.size() == 0) check("rd_extra", {31'd0, s_ready}, 0);
              else check("rd_bit", {31'd0, s_dout}, {31'd0, rq.pop_front()});
            end
          end else begin
            check("rd_quiet", {29'd0, s_ready, s_dout, mem_wren}, 0);
          end
        end
      end
      s_valid = (k < last);
      s_din   = (k <= 20) ? seq[20 - k] : 1'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_val(i);
    tbl[0] = '{1'b0, 12'h003, 8'h00};
    tbl[1] = '{1'b1, 12'h003, 8'hA5};
    tbl[2] = '{1'b0, 12'h003, 8'h00};
    tbl[3] = '{1'b1, 12'hFFF, 8'h00};
    tbl[4] = '{1'b0, 12'hFFF, 8'h00};
    tbl[5] = '{1'b1, 12'hFFF, 8'hFF};
    tbl[6] = '{1'b0, 12'hFFF, 8'h00};
    tbl[7] = '{1'b0, 12'h003, 8'h00};
    tbl[8] = '{1'b1, 12'h800, 8'h5A};
    tbl[9] = '{1'b0, 12'h800, 8'h00};

    #1;
    check("reset_state", {9'd0, s_dout, s_ready, mem_wren, mem_address, mem_data_in}, 0);
    repeat (2) @(negedge clock);
    rstn = 1'b1;

    // Reset lands mid write-data; the old RAM value must survive (tbl[0] reads it).
    txn(1'b1, 12'h003, 8'h77, -1, 15, 0);

    for (int i = 0; i < 10; i++) txn(tbl[i].wr, tbl[i].a, tbl[i].d, -1, -1, 0);

    txn(1'b1, 12'hFFF, 8'h00, 8, -1, 0);
    txn(1'b0, 12'hFFF, 8'h00, -1, -1, 0);
    txn(1'b1, 12'h003, 8'h11, 17, -1, 0);
    txn(1'b0, 12'h003, 8'h00, -1, -1, 0);

    txn(1'b1, 12'h000, 8'hC3, -1, -1, 10);
    txn(1'b0, 12'h000, 8'h00, -1, -1, 0);

    repeat (3) @(negedge clock);
    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
